// File: rtl/cpu0_mult_unit.sv
// cpu0 A-stage pipelined multiplier: full 2*WIDTH product from four half-width partial products,
// returning the low word (MUL) or the high word under UU/SU/SS operand interpretation.
module cpu0_mult_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_mul_src1,
  input  logic [WIDTH-1:0] A_mul_src2,
  input  logic [1:0]       A_mul_op,
  input  logic             A_mul_start,
  input  logic             A_mul_stall,
  output logic [WIDTH-1:0] A_mul_result,
  output logic             A_mul_done,
  output logic             A_mul_busy
);

  localparam int H  = WIDTH / 2;
  localparam int PW = WIDTH + 2;

  typedef struct packed {
    logic [1:0]    op;
    logic [PW-1:0] ll;
    logic [PW-1:0] lh;
    logic [PW-1:0] hl;
    logic [PW-1:0] hh;
  } ppBundle_t;

  logic [WIDTH-1:0]   r_src1;
  logic [WIDTH-1:0]   r_src2;
  logic [1:0]         r_op;
  logic [LATENCY-1:0] r_valid;
  logic [WIDTH-1:0]   r_result;

  logic                w_aSigned;
  logic                w_bSigned;
  logic signed [H:0]   w_aLo;
  logic signed [H:0]   w_aHi;
  logic signed [H:0]   w_bLo;
  logic signed [H:0]   w_bHi;
  ppBundle_t           w_ppComb;
  ppBundle_t           w_ppFinal;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_word;

  function automatic logic [2*WIDTH-1:0] sext(input logic [PW-1:0] x);
    return {{(2*WIDTH-PW){x[PW-1]}}, x};
  endfunction

  always_ff @(posedge clk) begin
    if (!A_mul_stall && A_mul_start) begin
      r_src1 <= A_mul_src1;
      r_src2 <= A_mul_src2;
      r_op   <= A_mul_op;
    end
  end

  // Halves carry one extra bit so the high halves can be sign- or zero-extended per op.
  always_comb begin
    w_aSigned   = r_op[1];
    w_bSigned   = (r_op == 2'b11);
    w_aLo       = {1'b0, r_src1[H-1:0]};
    w_aHi       = {w_aSigned & r_src1[WIDTH-1], r_src1[WIDTH-1:H]};
    w_bLo       = {1'b0, r_src2[H-1:0]};
    w_bHi       = {w_bSigned & r_src2[WIDTH-1], r_src2[WIDTH-1:H]};
    w_ppComb    = '0;
    w_ppComb.op = r_op;
    w_ppComb.ll = w_aLo * w_bLo;
    w_ppComb.lh = w_aLo * w_bHi;
    w_ppComb.hl = w_aHi * w_bLo;
    w_ppComb.hh = w_aHi * w_bHi;
  end

  generate
    if (LATENCY == 2) begin : gNoDelay
      assign w_ppFinal = w_ppComb;
    end else begin : gDelay
      ppBundle_t r_pp [LATENCY-2];

      always_ff @(posedge clk) begin
        if (!A_mul_stall) begin
          r_pp[0] <= w_ppComb;
          for (int i = 1; i < LATENCY-2; i++) begin
            r_pp[i] <= r_pp[i-1];
          end
        end
      end

      assign w_ppFinal = r_pp[LATENCY-3];
    end
  endgenerate

  always_comb begin
    w_prod = sext(w_ppFinal.ll)
           + (sext(w_ppFinal.lh) << H)
           + (sext(w_ppFinal.hl) << H)
           + (sext(w_ppFinal.hh) << WIDTH);
    w_word = (w_ppFinal.op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  // The result only loads when an operation reaches the last stage, so it holds between dones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_result <= '0;
    end else if (!A_mul_stall) begin
      r_valid <= {r_valid[LATENCY-2:0], A_mul_start};
      if (r_valid[LATENCY-2]) begin
        r_result <= w_word;
      end
    end
  end

  assign A_mul_result = r_result;
  assign A_mul_done   = r_valid[LATENCY-1];
  assign A_mul_busy   = |r_valid[LATENCY-2:0];

endmodule

// File: tb/tb_cpu0_mult_unit.sv
// Bench for cpu0_mult_unit: three instances (32/L2, 32/L3, 16/L4) checked against a
// whole-product arithmetic reference model.
module tb_cpu0_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a32, b32;
  logic [1:0]  op32;
  logic        start32, stall32;
  logic [31:0] res2, res3;
  logic        done2, done3, busy2, busy3;
  logic [15:0] a16, b16;
  logic [1:0]  op16;
  logic        start16, stall16;
  logic [15:0] res16;
  logic        done16, busy16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu0_mult_unit #(.WIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .A_mul_src1(a32), .A_mul_src2(b32), .A_mul_op(op32),
    .A_mul_start(start32), .A_mul_stall(stall32),
    .A_mul_result(res2), .A_mul_done(done2), .A_mul_busy(busy2)
  );

  cpu0_mult_unit #(.WIDTH(32), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .A_mul_src1(a32), .A_mul_src2(b32), .A_mul_op(op32),
    .A_mul_start(start32), .A_mul_stall(stall32),
    .A_mul_result(res3), .A_mul_done(done3), .A_mul_busy(busy3)
  );

  cpu0_mult_unit #(.WIDTH(16), .LATENCY(4)) u_w16 (
    .clk(clk), .reset(reset), .A_mul_src1(a16), .A_mul_src2(b16), .A_mul_op(op16),
    .A_mul_start(start16), .A_mul_stall(stall16),
    .A_mul_result(res16), .A_mul_done(done16), .A_mul_busy(busy16)
  );

  // Reference: extend both operands to 64 bits, multiply, pick the requested word.
  function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    longint ea, eb;
    logic [63:0] p;
    ea = op[1] ? longint'($signed(a)) : longint'(a);
    eb = (op == 2'b11) ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [15:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    longint ea, eb;
    logic [63:0] p;
    ea = op[1] ? longint'($signed(a)) : longint'(a);
    eb = (op == 2'b11) ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    return (op == 2'b00) ? p[15:0] : p[31:16];
  endfunction

  logic [31:0] dA   [9] = '{32'h0001_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
  logic [31:0] dB   [9] = '{32'h0002_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
  logic [1:0]  dOp  [9] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] dExp [9] = '{32'h000B_000F, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                            32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

  task automatic test_reset();
    reset = 1'b1; start32 = 1'b0; stall32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
    start16 = 1'b0; stall16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({res2, done2, busy2} !== 34'b0) begin
      errors++; $display("[TB] FAIL reset_l2 got res=%h done=%b busy=%b required all zero", res2, done2, busy2);
    end
    checks++;
    if ({res3, done3, busy3} !== 34'b0) begin
      errors++; $display("[TB] FAIL reset_l3 got res=%h done=%b busy=%b required all zero", res3, done3, busy3);
    end
    checks++;
    if ({res16, done16, busy16} !== 18'b0) begin
      errors++; $display("[TB] FAIL reset_w16 got res=%h done=%b busy=%b required all zero", res16, done16, busy16);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    for (int v = 0; v < 9; v++) begin
      int lat2, lat3;
      logic [31:0] got2, got3;
      lat2 = -1; lat3 = -1; got2 = '0; got3 = '0;
      @(negedge clk);
      a32 = dA[v]; b32 = dB[v]; op32 = dOp[v]; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      checks++;
      if (busy2 !== 1'b1) begin
        errors++; $display("[TB] FAIL directed[%0d] busy got %b required 1", v, busy2);
      end
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (done2 === 1'b1 && lat2 < 0) begin lat2 = k; got2 = res2; end
        if (done3 === 1'b1 && lat3 < 0) begin lat3 = k; got3 = res3; end
      end
      checks++;
      if (lat2 != 1) begin
        errors++; $display("[TB] FAIL directed[%0d] latency_l2 got %0d required 1", v, lat2);
      end
      checks++;
      if (got2 !== dExp[v]) begin
        errors++; $display("[TB] FAIL directed[%0d] result_l2 got %h required %h", v, got2, dExp[v]);
      end
      checks++;
      if (lat3 != 2) begin
        errors++; $display("[TB] FAIL directed[%0d] latency_l3 got %0d required 2", v, lat3);
      end
      checks++;
      if (got3 !== dExp[v]) begin
        errors++; $display("[TB] FAIL directed[%0d] result_l3 got %h required %h", v, got3, dExp[v]);
      end
      checks++;
      if (done2 !== 1'b0) begin
        errors++; $display("[TB] FAIL directed[%0d] done_pulse got %b required 0", v, done2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] itA [4], itB [4];
    logic [1:0]  itOp [4];
    logic [31:0] expQ [$];
    logic [31:0] expv, lastRes;
    logic        lastDone, prevStall;
    int          nDone;
    for (int i = 0; i < 4; i++) begin
      itA[i] = $urandom; itB[i] = $urandom; itOp[i] = 2'($urandom_range(0, 3));
    end
    prevStall = 1'b0; nDone = 0;
    lastDone = done3; lastRes = res3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (prevStall) begin
        checks++;
        if (done3 !== lastDone || res3 !== lastRes) begin
          errors++; $display("[TB] FAIL b2b_frozen c=%0d got done=%b res=%h required done=%b res=%h",
                             c, done3, res3, lastDone, lastRes);
        end
      end else if (done3 === 1'b1) begin
        nDone++;
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra_done c=%0d got res=%h required no done", c, res3);
        end else begin
          expv = expQ.pop_front();
          if (res3 !== expv) begin
            errors++; $display("[TB] FAIL b2b_result c=%0d got %h required %h", c, res3, expv);
          end
        end
      end
      lastDone = done3; lastRes = res3;
      if (c < 3) begin
        a32 = itA[c]; b32 = itB[c]; op32 = itOp[c]; start32 = 1'b1; stall32 = 1'b0;
      end else if (c < 5) begin
        a32 = itA[3]; b32 = itB[3]; op32 = itOp[3]; start32 = 1'b1; stall32 = 1'b1;
      end else if (c == 5) begin
        start32 = 1'b1; stall32 = 1'b0;
      end else begin
        start32 = 1'b0; stall32 = 1'b0;
      end
      if (start32 && !stall32) expQ.push_back(ref32(a32, b32, op32));
      prevStall = stall32;
    end
    checks++;
    if (nDone != 4 || expQ.size() != 0) begin
      errors++; $display("[TB] FAIL b2b_done_count got %0d pending=%0d required 4 pending=0", nDone, expQ.size());
    end
    checks++;
    if (busy3 !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_busy_idle got %b required 0", busy3);
    end
  endtask

  task automatic test_reset_inflight();
    logic sawDone;
    @(negedge clk);
    a32 = $urandom | 32'h0001_0001; b32 = $urandom | 32'h0001_0001; op32 = 2'b00;
    start32 = 1'b1; stall32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0; stall32 = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; stall32 = 1'b0;
    checks++;
    if ({res2, done2, busy2} !== 34'b0) begin
      errors++; $display("[TB] FAIL inflight_reset_l2 got res=%h done=%b busy=%b required all zero", res2, done2, busy2);
    end
    checks++;
    if ({res3, done3, busy3} !== 34'b0) begin
      errors++; $display("[TB] FAIL inflight_reset_l3 got res=%h done=%b busy=%b required all zero", res3, done3, busy3);
    end
    sawDone = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done2 !== 1'b0 || done3 !== 1'b0) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++; $display("[TB] FAIL inflight_no_done got a done pulse required none");
    end
  endtask

  task automatic test_random16();
    logic [15:0] expQ [$];
    int          cycQ [$];
    logic [15:0] expv;
    int          issueCyc, issued;
    issued = 0;
    for (int cyc = 0; cyc < 6000 && (issued < 1000 || expQ.size() > 0); cyc++) begin
      @(negedge clk);
      if (done16 === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++; $display("[TB] FAIL rand16_extra_done cyc=%0d got res=%h required no done", cyc, res16);
        end else begin
          expv = expQ.pop_front();
          issueCyc = cycQ.pop_front();
          checks++;
          if (res16 !== expv) begin
            errors++; $display("[TB] FAIL rand16_result cyc=%0d got %h required %h", cyc, res16, expv);
          end
          checks++;
          if (cyc - issueCyc != 4) begin
            errors++; $display("[TB] FAIL rand16_latency cyc=%0d got %0d required 4", cyc, cyc - issueCyc);
          end
        end
      end
      if (issued < 1000 && $urandom_range(0, 3) != 0) begin
        a16 = 16'($urandom); b16 = 16'($urandom); op16 = 2'($urandom_range(0, 3));
        start16 = 1'b1;
        expQ.push_back(ref16(a16, b16, op16));
        cycQ.push_back(cyc);
        issued++;
      end else begin
        start16 = 1'b0;
      end
    end
    start16 = 1'b0;
    checks++;
    if (issued != 1000 || expQ.size() != 0) begin
      errors++; $display("[TB] FAIL rand16_complete got issued=%0d pending=%0d required 1000 and 0", issued, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
